motor_ramp_sequencer: RTL and testbench
=======================================

# motor_ramp_sequencer

Sequences one MotorPWM channel in the 2 kHz domain: converts raw operator requests (enable, direction, duty) into a rate-limited duty-cycle ramp, enforces ramp-to-zero plus dead time before any direction reversal, and provides a latched emergency stop. Sits between the switch/request logic and each MotorPWM instance, one sequencer per motor.

## Interface
- RAMP_DIV, 20: Clock2K cycles per ramp step (20 = 10 ms); ≥1
- STEP, 1: duty change per ramp step, 1..255
- DEAD_TICKS, 200: cycles motor held disabled between stop and reversal; ≥1
- Clock2K  in  1  2 kHz clock, single clock domain
- Resetn  in  1  synchronous active-low reset
- en_req  in  1  run request
- dir_req  in  1  requested direction
- duty_req  in  8  requested duty cycle, 0..255
- estop  in  1  emergency stop, level, highest priority
- duty_cycle  out  8  duty to MotorPWM
- motor_en  out  1  enable to MotorPWM
- motor_dir  out  1  committed direction
- busy  out  1  high in RAMP, STOP, DEAD
- state  out  3  current FSM state code
- fault  out  1  high in ESTOP

## Operation
- Effective target T = en_req ? duty_req : 0, sampled every cycle; T changes mid-ramp are tracked immediately.
- Step counter: cleared to 0 in IDLE, RUN, DEAD, ESTOP; increments in RAMP/STOP; tick when counter == RAMP_DIV-1, then wraps to 0.
- Step arithmetic (9-bit internal, no wrap): up: duty = min(duty+STEP, T); down: duty = (duty−T ≤ STEP) ? T : duty−STEP. Never overshoots T; 255 never wraps to 0.
- States (code):
  - IDLE (0): duty 0, motor_en 0. en_req && duty_req≠0 → RAMP, motor_dir ← dir_req on the same edge.
  - RAMP (1): motor_en 1. dir_req≠motor_dir → STOP. Else step toward T on tick; duty==T≠0 → RUN; duty==T==0 → IDLE.
  - RUN (2): motor_en 1, duty held. dir_req≠motor_dir → STOP; else T≠duty → RAMP.
  - STOP (3): motor_en 1, ramps toward 0 on tick regardless of T; duty==0 → DEAD.
  - DEAD (4): duty 0, motor_en 0; counts DEAD_TICKS cycles → IDLE (relaunches with new dir_req if requested).
  - ESTOP (5): duty 0, motor_en 0, fault 1. Exit → IDLE only when estop==0 && en_req==0.
- Priority per cycle: Resetn > estop > direction change > target tracking.
- en_req drop while running: ramps to 0 via RAMP, returns to IDLE, no dead time, motor_dir unchanged.
- dir_req toggling in IDLE/DEAD/ESTOP has no effect until launch.

## Timing
- All outputs registered; response visible the edge after the causing input.
- Reset values: duty_cycle 0, motor_en 0, motor_dir 0, busy 0, state 0, fault 0; Resetn low mid-operation forces these on the next edge, counters cleared.
- First ramp step RAMP_DIV cycles after entering RAMP/STOP; subsequent steps every RAMP_DIV cycles.
- RAMP↔RUN transitions do not restart a pending step beyond the counter-clear rule.
- DEAD lasts exactly DEAD_TICKS cycles with motor_en 0.
- estop asserted: ESTOP, duty 0, motor_en 0 on next edge from any state.

## Configuration
- MOTOR_SEQ_ESTOP_EN defined: estop input active as above, ESTOP state and fault implemented.
- Undefined: estop port present but ignored, ESTOP unreachable, fault tied 0.

## Test plan
- RAMP_DIV=4, STEP=16: IDLE, en_req=1, duty_req=64, dir_req=0 → duty 16,32,48,64 at 4-cycle intervals, then state 2, motor_en 1, motor_dir 0.
- From RUN at 64: duty_req=70 → one step to 70, RUN; duty_req=10 → 54,38,22,10, RUN; duty_req=255 from 240 → 255, no wrap.
- DEAD_TICKS=8, RUN at 48, dir_req→1 → STOP: 32,16,0; DEAD with motor_en 0 for 8 cycles; IDLE; RAMP with motor_dir 1 to 48.
- en_req→0 in RUN at 32 → 16,0, state 0, motor_dir unchanged, no DEAD.
- MOTOR_SEQ_ESTOP_EN, estop=1 mid-RAMP → next edge state 5, duty 0, motor_en 0, fault 1; estop=0 with en_req=1 → stays ESTOP; en_req=0 → IDLE, fault 0.
- Resetn=0 for one cycle in RUN at 128 → all outputs 0, state 0 next edge; resumes ramping from 0 when released with en_req=1.

Source files
------------

// File: rtl/motor_ramp_sequencer_if.sv
// Request/status bundle between switch logic and one motor ramp sequencer.
// Combinational wiring only; no latency of its own.
// No backpressure: requests are level signals sampled every cycle.
interface motor_ramp_sequencer_if;
    logic       en_req;
    logic       dir_req;
    logic [7:0] duty_req;
    logic       estop;
    logic [7:0] duty_cycle;
    logic       motor_en;
    logic       motor_dir;
    logic       busy;
    logic [2:0] state;
    logic       fault;

    modport master (
        output en_req, dir_req, duty_req, estop,
        input  duty_cycle, motor_en, motor_dir, busy, state, fault
    );

    modport slave (
        input  en_req, dir_req, duty_req, estop,
        output duty_cycle, motor_en, motor_dir, busy, state, fault
    );
endinterface

// File: rtl/motor_ramp_sequencer.sv
// Rate-limited duty ramp with stop/dead-time before reversal; latched e-stop when MOTOR_SEQ_ESTOP_EN is defined.
// Latency: every output registered, reacts on the edge after the causing input.
// Backpressure: none; level requests are re-sampled every cycle and tracked immediately.
module motor_ramp_sequencer #(
    parameter int RAMP_DIV   = 20,
    parameter int STEP       = 1,
    parameter int DEAD_TICKS = 200
) (
    input  logic                    Clock2K,
    input  logic                    Resetn,
    motor_ramp_sequencer_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RAMP  = 3'd1,
        S_RUN   = 3'd2,
        S_STOP  = 3'd3,
        S_DEAD  = 3'd4,
        S_ESTOP = 3'd5
    } state_t;

    localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DW = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(RAMP_DIV - 1);
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_TICKS - 1);
    localparam logic [8:0]    STEP9     = 9'(STEP);

    state_t        r_state, w_state_n;
    logic [7:0]    r_duty, w_duty_n;
    logic          r_dir, w_dir_n;
    logic          r_en, r_busy, r_fault;
    logic [CW-1:0] r_cnt, w_cnt_n;
    logic [DW-1:0] r_dead, w_dead_n;

    logic          w_estop;
    logic [7:0]    w_target;
    logic [7:0]    w_step_tgt;
    logic          w_tick;
    logic [8:0]    w_d9, w_t9, w_up, w_dn;
    logic [7:0]    w_stepped;

`ifdef MOTOR_SEQ_ESTOP_EN
    assign w_estop = bus.estop;
`else
    // Port kept for drop-in compatibility; its value never reaches the FSM.
    assign w_estop = bus.estop & 1'b0;
`endif

    assign w_target   = bus.en_req ? bus.duty_req : 8'd0;
    assign w_step_tgt = (r_state == S_STOP) ? 8'd0 : w_target;
    assign w_tick     = (r_cnt == TICK_LAST);

    // 9-bit step math so 255 saturates instead of wrapping and we never pass the target.
    always_comb begin
        w_d9      = {1'b0, r_duty};
        w_t9      = {1'b0, w_step_tgt};
        w_up      = w_d9 + STEP9;
        w_dn      = w_d9 - STEP9;
        w_stepped = w_step_tgt;
        if (w_t9 > w_d9) begin
            if (w_up < w_t9) w_stepped = w_up[7:0];
        end else if ((w_d9 - w_t9) > STEP9) begin
            w_stepped = w_dn[7:0];
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_duty_n  = r_duty;
        w_dir_n   = r_dir;
        w_dead_n  = '0;
        w_cnt_n   = '0;
        if (w_estop) begin
            w_state_n = S_ESTOP;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.en_req && (bus.duty_req != 8'd0)) begin
                        w_state_n = S_RAMP;
                        w_dir_n   = bus.dir_req;
                    end
                end
                S_RAMP: begin
                    if (bus.dir_req != r_dir)
                        w_state_n = S_STOP;
                    else if (r_duty == w_target)
                        w_state_n = (w_target == 8'd0) ? S_IDLE : S_RUN;
                    else if (w_tick)
                        w_duty_n = w_stepped;
                end
                S_RUN: begin
                    if (bus.dir_req != r_dir)
                        w_state_n = S_STOP;
                    else if (w_target != r_duty)
                        w_state_n = S_RAMP;
                end
                S_STOP: begin
                    if (r_duty == 8'd0)
                        w_state_n = S_DEAD;
                    else if (w_tick)
                        w_duty_n = w_stepped;
                end
                S_DEAD: begin
                    if (r_dead == DEAD_LAST)
                        w_state_n = S_IDLE;
                    else
                        w_dead_n = r_dead + 1'b1;
                end
                S_ESTOP: begin
                    if (!bus.en_req)
                        w_state_n = S_IDLE;
                end
                default: w_state_n = S_IDLE;
            endcase
        end
        // Step counter only survives while staying in RAMP or STOP; any entry starts a fresh interval.
        if (((w_state_n == S_RAMP) || (w_state_n == S_STOP)) && (w_state_n == r_state))
            w_cnt_n = w_tick ? '0 : r_cnt + 1'b1;
        if ((w_state_n == S_IDLE) || (w_state_n == S_DEAD) || (w_state_n == S_ESTOP))
            w_duty_n = 8'd0;
    end

    always_ff @(posedge Clock2K) begin
        if (!Resetn) begin
            r_state <= S_IDLE;
            r_duty  <= 8'd0;
            r_dir   <= 1'b0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_fault <= 1'b0;
            r_cnt   <= '0;
            r_dead  <= '0;
        end else begin
            r_state <= w_state_n;
            r_duty  <= w_duty_n;
            r_dir   <= w_dir_n;
            r_en    <= (w_state_n == S_RAMP) || (w_state_n == S_RUN) || (w_state_n == S_STOP);
            r_busy  <= (w_state_n == S_RAMP) || (w_state_n == S_STOP) || (w_state_n == S_DEAD);
            r_fault <= (w_state_n == S_ESTOP);
            r_cnt   <= w_cnt_n;
            r_dead  <= w_dead_n;
        end
    end

    assign bus.duty_cycle = r_duty;
    assign bus.motor_en   = r_en;
    assign bus.motor_dir  = r_dir;
    assign bus.busy       = r_busy;
    assign bus.state      = r_state;
    assign bus.fault      = r_fault;
endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// Directed bench for motor_ramp_sequencer with a per-cycle behavioural reference.
module tb_motor_ramp_sequencer;
    localparam int RD = 4;
    localparam int ST = 16;
    localparam int DT = 8;
`ifdef MOTOR_SEQ_ESTOP_EN
    localparam bit ESTOP_ON = 1'b1;
`else
    localparam bit ESTOP_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    bit   chk_en = 1'b0;

    motor_ramp_sequencer_if bus ();

    motor_ramp_sequencer #(.RAMP_DIV(RD), .STEP(ST), .DEAD_TICKS(DT)) dut (
        .Clock2K (clk),
        .Resetn  (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference: phase number doubles as the published state code.
    int m_ph = 0;
    int m_duty = 0;
    int m_dir = 0;
    int m_age = 0;

    function automatic int approach(input int d, input int t);
        if (t > d) return (d + ST < t) ? d + ST : t;
        return (d - t <= ST) ? t : d - ST;
    endfunction

    always @(posedge clk) begin
        int tgt;
        tgt = bus.en_req ? int'(bus.duty_req) : 0;
        if (!rst_n) begin
            m_ph = 0; m_duty = 0; m_dir = 0; m_age = 0;
        end else if (ESTOP_ON && bus.estop) begin
            m_ph = 5; m_duty = 0; m_age = 0;
        end else begin
            case (m_ph)
                0: if (bus.en_req && bus.duty_req != 0) begin
                       m_ph = 1; m_dir = int'(bus.dir_req); m_age = 0;
                   end
                1: if (int'(bus.dir_req) != m_dir) begin
                       m_ph = 3; m_age = 0;
                   end else if (m_duty == tgt) begin
                       m_ph = (tgt == 0) ? 0 : 2;
                   end else if (m_age % RD == RD - 1) begin
                       m_duty = approach(m_duty, tgt); m_age = 0;
                   end else m_age++;
                2: if (int'(bus.dir_req) != m_dir) begin
                       m_ph = 3; m_age = 0;
                   end else if (tgt != m_duty) begin
                       m_ph = 1; m_age = 0;
                   end
                3: if (m_duty == 0) begin
                       m_ph = 4; m_age = 0;
                   end else if (m_age % RD == RD - 1) begin
                       m_duty = approach(m_duty, 0); m_age = 0;
                   end else m_age++;
                4: if (m_age >= DT - 1) m_ph = 0; else m_age++;
                default: if (!bus.estop && !bus.en_req) m_ph = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        bit e_en, e_busy, e_flt;
        if (chk_en) begin
            e_en   = (m_ph == 1) || (m_ph == 2) || (m_ph == 3);
            e_busy = (m_ph == 1) || (m_ph == 3) || (m_ph == 4);
            e_flt  = (m_ph == 5);
            checks++;
            if (int'(bus.state) != m_ph || int'(bus.duty_cycle) != m_duty ||
                bus.motor_en !== e_en || int'(bus.motor_dir) != m_dir ||
                bus.busy !== e_busy || bus.fault !== e_flt) begin
                failures++;
                $display("FAIL cycle_cmp t=%0t got st=%0d duty=%0d en=%b dir=%b busy=%b flt=%b want st=%0d duty=%0d en=%b dir=%0d busy=%b flt=%b",
                         $time, bus.state, bus.duty_cycle, bus.motor_en, bus.motor_dir, bus.busy, bus.fault,
                         m_ph, m_duty, e_en, m_dir, e_busy, e_flt);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic lit(input string name, input int got, input int mdl, input int want);
        checks++;
        if (got != want || mdl != want) begin
            failures++;
            $display("FAIL %s: dut=%0d model=%0d expected=%0d", name, got, mdl, want);
        end
    endtask

    task automatic wait_for(input string name, input int st, input int duty, input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (int'(bus.state) == st && int'(bus.duty_cycle) == duty) begin
                hit = 1'b1;
                break;
            end
            tick(1);
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL %s: timeout state=%0d duty=%0d expected state=%0d duty=%0d",
                     name, bus.state, bus.duty_cycle, st, duty);
        end
    endtask

    task automatic chk_st(input string name, input int st, input int duty);
        lit({name, "_state"}, int'(bus.state), m_ph, st);
        lit({name, "_duty"}, int'(bus.duty_cycle), m_duty, duty);
    endtask

    initial begin
        bus.en_req = 1'b0; bus.dir_req = 1'b0; bus.duty_req = 8'd0; bus.estop = 1'b0;
        tick(3);
        chk_en = 1'b1;
        chk_st("reset", 0, 0);
        lit("reset_en", int'(bus.motor_en), 0, 0);
        lit("reset_dir", int'(bus.motor_dir), m_dir, 0);
        lit("reset_busy", int'(bus.busy), 0, 0);
        lit("reset_fault", int'(bus.fault), 0, 0);

        // Launch and ramp to 64.
        rst_n = 1'b1; bus.en_req = 1'b1; bus.duty_req = 8'd64;
        tick(1); chk_st("launch", 1, 0);
        lit("launch_en", int'(bus.motor_en), 1, 1);
        tick(4); chk_st("up16", 1, 16);
        tick(4); chk_st("up32", 1, 32);
        tick(4); chk_st("up48", 1, 48);
        tick(4); chk_st("up64", 1, 64);
        tick(1); chk_st("run64", 2, 64);
        lit("run64_dir", int'(bus.motor_dir), m_dir, 0);

        // Retarget while running.
        bus.duty_req = 8'd70;
        tick(1); chk_st("to70_ramp", 1, 64);
        tick(4); chk_st("to70", 1, 70);
        tick(1); chk_st("run70", 2, 70);
        bus.duty_req = 8'd10;
        tick(5); chk_st("dn54", 1, 54);
        tick(4); chk_st("dn38", 1, 38);
        tick(4); chk_st("dn22", 1, 22);
        tick(4); chk_st("dn10", 1, 10);
        tick(1); chk_st("run10", 2, 10);
        bus.duty_req = 8'd240;
        tick(61); chk_st("up240", 1, 240);
        tick(1); chk_st("run240", 2, 240);
        bus.duty_req = 8'd255;
        tick(5); chk_st("sat255", 1, 255);
        tick(1); chk_st("run255", 2, 255);

        // Reversal: stop, dead time, relaunch the other way.
        bus.duty_req = 8'd48;
        wait_for("reach48", 2, 48, 80);
        bus.dir_req = 1'b1;
        tick(1); chk_st("stop", 3, 48);
        lit("stop_dir_held", int'(bus.motor_dir), m_dir, 0);
        tick(4); chk_st("stop32", 3, 32);
        tick(4); chk_st("stop16", 3, 16);
        tick(4); chk_st("stop0", 3, 0);
        tick(1); chk_st("dead_in", 4, 0);
        lit("dead_en", int'(bus.motor_en), 0, 0);
        tick(7); chk_st("dead_last", 4, 0);
        tick(1); chk_st("dead_out", 0, 0);
        tick(1); chk_st("relaunch", 1, 0);
        lit("relaunch_dir", int'(bus.motor_dir), m_dir, 1);
        tick(12); chk_st("rev48", 1, 48);
        tick(1); chk_st("rev_run", 2, 48);

        // Enable drop: ramp down, straight to IDLE.
        bus.duty_req = 8'd32;
        tick(6); chk_st("run32", 2, 32);
        bus.en_req = 1'b0;
        tick(1); chk_st("off_ramp", 1, 32);
        tick(4); chk_st("off16", 1, 16);
        tick(4); chk_st("off0", 1, 0);
        tick(1); chk_st("off_idle", 0, 0);
        lit("off_dir", int'(bus.motor_dir), m_dir, 1);

        // Emergency stop mid-ramp.
        bus.en_req = 1'b1; bus.duty_req = 8'd64;
        tick(1); chk_st("es_launch", 1, 0);
        tick(2);
        bus.estop = 1'b1;
        tick(1);
`ifdef MOTOR_SEQ_ESTOP_EN
        chk_st("estop", 5, 0);
        lit("estop_en", int'(bus.motor_en), 0, 0);
        lit("estop_fault", int'(bus.fault), 1, 1);
        bus.estop = 1'b0;
        tick(3); chk_st("estop_hold", 5, 0);
        bus.en_req = 1'b0;
        tick(1); chk_st("estop_exit", 0, 0);
        lit("estop_clr", int'(bus.fault), 0, 0);
`else
        chk_st("estop_ignored", 1, 0);
        lit("estop_nofault", int'(bus.fault), 0, 0);
        bus.estop = 1'b0; bus.en_req = 1'b0;
        wait_for("es_idle", 0, 0, 40);
`endif

        // Reset mid-run.
        bus.en_req = 1'b1; bus.duty_req = 8'd128;
        wait_for("reach128", 2, 128, 200);
        rst_n = 1'b0;
        tick(1); chk_st("rst_run", 0, 0);
        lit("rst_en", int'(bus.motor_en), 0, 0);
        lit("rst_dir", int'(bus.motor_dir), m_dir, 0);
        rst_n = 1'b1;
        tick(1); chk_st("rst_relaunch", 1, 0);
        tick(4); chk_st("rst_up16", 1, 16);
        bus.en_req = 1'b0;
        tick(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
